// File: rtl/irq_event_coalescer.sv
// irq_event_coalescer: per-channel event coalescing, pulse shaping and holdoff
// ahead of the 16-input vectored interrupt controller. All state changes on the
// falling edge of sclk; rst clears everything immediately.
module irq_event_coalescer #(
    parameter int PULSE_W = 4,
    parameter int HOLD_W  = 8
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        wen,
    input  logic [1:0]  wa,
    input  logic [15:0] di,
    input  logic [15:0] ev,
    output logic [15:0] irq_out,
    output logic [15:0] ovf,
    output logic [15:0] pend
);

    // One timer serves both the pulse length and the holdoff wait.
    localparam int TMR_W = (HOLD_W > 4) ? HOLD_W : 4;

    typedef enum logic [1:0] {
        ST_COUNT = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic        wen_q;
    logic [1:0]  wa_q;
    logic [15:0] di_q;
    logic [15:0] enable_q;
    logic [15:0] flush_vec;

    // Register the write port; the decoded write lands one edge later.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            wen_q <= 1'b0;
            wa_q  <= 2'd0;
            di_q  <= 16'h0000;
        end else begin
            wen_q <= wen;
            wa_q  <= wa;
            di_q  <= di;
        end
    end

    // Enable mask is written as a whole word.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            enable_q <= 16'h0000;
        end else if (wen_q && (wa_q == 2'd2)) begin
            enable_q <= di_q;
        end
    end

    assign flush_vec = (wen_q && (wa_q == 2'd3)) ? di_q : 16'h0000;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_ch
            logic [3:0]        thr_q;
            logic [HOLD_W-1:0] hold_q;
            logic [3:0]        cnt_q;
            logic [3:0]        cnt_d;
            logic [3:0]        cnt_next;
            logic [3:0]        thr_eff;
            logic [TMR_W-1:0]  tmr_q;
            state_t            state_q;
            logic              irq_q;
            logic              ovf_q;
            logic              pend_q;
            logic              sel;
            logic              ev_ok;
            logic              sat;
            logic              fire;

            assign sel = (di_q[11:8] == 4'(gi));

            // Saturating event count, threshold compare and post-fire remainder.
            always_comb begin
                ev_ok    = ev[gi] & enable_q[gi];
                sat      = ev_ok && (cnt_q == 4'hF);
                cnt_next = (ev_ok && !sat) ? cnt_q + 4'd1 : cnt_q;
                thr_eff  = (thr_q == 4'd0) ? 4'd1 : thr_q;
                fire     = (state_q == ST_COUNT) && (cnt_next >= thr_eff);
                cnt_d    = fire ? cnt_next - thr_eff : cnt_next;
            end

            // Per-channel threshold and holdoff configuration.
            always_ff @(negedge sclk or posedge rst) begin
                if (rst) begin
                    thr_q  <= 4'd1;
                    hold_q <= '0;
                end else if (wen_q && sel) begin
                    if (wa_q == 2'd0) thr_q  <= di_q[3:0];
                    if (wa_q == 2'd1) hold_q <= di_q[HOLD_W-1:0];
                end
            end

            // Channel FSM with count, sticky overflow and flopped outputs.
            always_ff @(negedge sclk or posedge rst) begin
                if (rst) begin
                    state_q <= ST_COUNT;
                    cnt_q   <= 4'd0;
                    tmr_q   <= '0;
                    irq_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                    pend_q  <= 1'b0;
                end else if (flush_vec[gi]) begin
                    // Flush wins over a coincident event and may cut a pulse short.
                    state_q <= ST_COUNT;
                    cnt_q   <= 4'd0;
                    tmr_q   <= '0;
                    irq_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                    pend_q  <= 1'b0;
                end else begin
                    // Output trails the state by one edge so it comes straight off a flop.
                    irq_q  <= (state_q == ST_PULSE);
                    cnt_q  <= cnt_d;
                    pend_q <= (cnt_d != 4'd0);
                    if (sat) ovf_q <= 1'b1;
                    case (state_q)
                        ST_COUNT: begin
                            if (fire) begin
                                state_q <= ST_PULSE;
                                tmr_q   <= TMR_W'(PULSE_W);
                            end
                        end
                        ST_PULSE: begin
                            if (tmr_q == TMR_W'(1)) begin
                                if (hold_q == '0) begin
                                    state_q <= ST_COUNT;
                                end else begin
                                    state_q <= ST_HOLD;
                                    tmr_q   <= TMR_W'(hold_q);
                                end
                            end else begin
                                tmr_q <= tmr_q - TMR_W'(1);
                            end
                        end
                        ST_HOLD: begin
                            if (tmr_q == TMR_W'(1)) begin
                                state_q <= ST_COUNT;
                            end else begin
                                tmr_q <= tmr_q - TMR_W'(1);
                            end
                        end
                        default: state_q <= ST_COUNT;
                    endcase
                end
            end

            assign irq_out[gi] = irq_q;
            assign ovf[gi]     = ovf_q;
            assign pend[gi]    = pend_q;
        end
    endgenerate

endmodule
